// File: rtl/rand_req_arbiter.sv
// Shares one random-number generator between NUM_REQ requesters: round-robin
// grant, one rise strobe per draw, then a MIN_GAP idle window before the next draw.
module rand_req_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MIN_GAP = 3,
  localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rng_rise,
  input  logic [DATA_W-1:0]  rng_dout,
  output logic               busy,
  output logic [ID_W-1:0]    grant_id
);

  localparam int unsigned     GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (MIN_GAP != 0) ? GAP_W'(MIN_GAP - 1) : '0;
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {IDLE, FIRE, CAPTURE, RESP, GAP} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    last_served, last_served_nxt;
  logic [ID_W-1:0]    winner, grant_id_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic [NUM_REQ-1:0] ack_nxt;
  logic [DATA_W-1:0]  rsp_data_nxt;
  logic               rng_rise_nxt, busy_nxt;

  // Round-robin search starting one past the last served index, wrapping at NUM_REQ.
  always_comb begin
    logic [ID_W-1:0] idx;
    logic            found;
    winner = last_served;
    found  = 1'b0;
    idx    = last_served;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (idx == LAST_RST) ? '0 : idx + 1'b1;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      ack         <= '0;
      rng_rise    <= 1'b0;
      busy        <= 1'b0;
      rsp_data    <= '0;
      grant_id    <= '0;
      last_served <= LAST_RST;
      gap_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      ack         <= ack_nxt;
      rng_rise    <= rng_rise_nxt;
      busy        <= busy_nxt;
      rsp_data    <= rsp_data_nxt;
      grant_id    <= grant_id_nxt;
      last_served <= last_served_nxt;
      gap_cnt     <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = FIRE;
      FIRE:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = (MIN_GAP != 0) ? GAP : IDLE;
      GAP:     if (gap_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead from the next state so they land registered.
  always_comb begin
    ack_nxt         = '0;
    rng_rise_nxt    = (state_nxt == FIRE);
    busy_nxt        = (state_nxt != IDLE);
    rsp_data_nxt    = rsp_data;
    grant_id_nxt    = grant_id;
    last_served_nxt = last_served;
    gap_cnt_nxt     = gap_cnt;
    case (state)
      IDLE:    if (|req) grant_id_nxt = winner;
      CAPTURE: begin
        rsp_data_nxt      = rng_dout;
        ack_nxt[grant_id] = 1'b1;
      end
      RESP: begin
        last_served_nxt = grant_id;
        gap_cnt_nxt     = GAP_LOAD;
      end
      GAP:     if (gap_cnt != '0) gap_cnt_nxt = gap_cnt - 1'b1;
      default: ;
    endcase
  end

endmodule
